gram_scheduler: RTL and testbench

//  Sequences the shared dot_product datapath to build a Gram matrix G[i][j] = v_i . v_j over N_VEC stored vectors.

---
 rtl/gram_scheduler_if.sv | 46 ++++
 rtl/gram_scheduler.sv | 169 ++++++++++++++++
 tb/tb_gram_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gram_scheduler_if.sv
// Bus bundle between the Gram scheduler and its surroundings: control
// handshake, row-read port, dot_product operand/result wires and the
// result stream. The master modport is the scheduler's view.
interface gram_scheduler_if #(
  parameter int SIZE = 64
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_req;
  logic [4:0]          rd_addr;
  logic                rd_valid;
  logic [SIZE*32-1:0]  rd_data;
  logic [SIZE*32-1:0]  dp_in1;
  logic [SIZE*32-1:0]  dp_in2;
  logic [10:0]         dp_index;
  logic [31:0]         dp_out;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_data;
  logic [10:0]         res_index;

  modport master (
    input  start,
    output busy, done,
    output rd_req, rd_addr,
    input  rd_valid, rd_data,
    output dp_in1, dp_in2, dp_index,
    input  dp_out,
    output res_valid,
    input  res_ready,
    output res_data, res_index
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_req, rd_addr,
    output rd_valid, rd_data,
    input  dp_in1, dp_in2, dp_index,
    output dp_out,
    input  res_valid,
    output res_ready,
    input  res_data, res_index
  );
endinterface

// File: rtl/gram_scheduler.sv
// Gram matrix scheduler: walks the upper triangle (j >= i) of N_VEC vectors,
// fetches operand rows, holds them on the shared dot_product, captures the
// result after DP_LAT+1 cycles and streams it out on a valid/ready port.
// Optional feature macro GRAM_MIRROR_EN: every off-diagonal result is
// re-emitted with the transposed index, giving the full N_VEC*N_VEC matrix.
module gram_scheduler #(
  parameter int SIZE   = 64,
  parameter int N_VEC  = 16,
  parameter int DP_LAT = 0
) (
  input logic             clk,
  input logic             reset,
  gram_scheduler_if.master bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_A  = 3'd1;
  localparam logic [2:0] LOAD_B  = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] EMIT    = 3'd4;
`ifdef GRAM_MIRROR_EN
  localparam logic [2:0] EMIT_M  = 3'd5;
`endif
  localparam logic [2:0] FIN     = 3'd6;

  localparam logic [10:0] NV   = 11'(N_VEC);
  localparam logic [4:0]  LAST = 5'(N_VEC - 1);
  localparam logic [7:0]  LAT  = 8'(DP_LAT);

  logic [2:0]         state_reg;
  logic [4:0]         i_reg;
  logic [4:0]         j_reg;
  logic [7:0]         wait_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               res_valid_reg;
  logic [31:0]        res_data_reg;
  logic [10:0]        res_index_reg;
  logic [SIZE*32-1:0] dp_in1_reg;
  logic [SIZE*32-1:0] dp_in2_reg;
  logic [10:0]        pair_index;
  logic               accept;
  logic               advance;

  assign pair_index = 11'(i_reg) * NV + 11'(j_reg);
  assign accept     = res_valid_reg & bus.res_ready;

`ifdef GRAM_MIRROR_EN
  logic [10:0] mirror_index;
  assign mirror_index = 11'(j_reg) * NV + 11'(i_reg);
`endif

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.rd_req    = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign bus.rd_addr   = (state_reg == LOAD_B) ? j_reg : i_reg;
  assign bus.dp_in1    = dp_in1_reg;
  assign bus.dp_in2    = dp_in2_reg;
  assign bus.dp_index  = pair_index;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_index = res_index_reg;

  // Decide whether the accepted result finishes the current pair
  always_comb begin
    advance = 1'b0;
    if (accept && state_reg == EMIT) begin
      advance = 1'b1;
    end
`ifdef GRAM_MIRROR_EN
    if (accept && state_reg == EMIT && i_reg != j_reg) begin
      advance = 1'b0;
    end
    if (accept && state_reg == EMIT_M) begin
      advance = 1'b1;
    end
`endif
  end

  // Pass sequencer: fetch, compute, emit, and step (i, j) in row-major order
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      i_reg         <= '0;
      j_reg         <= '0;
      wait_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_index_reg <= '0;
      dp_in1_reg    <= '0;
      dp_in2_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            busy_reg  <= 1'b1;
            i_reg     <= '0;
            j_reg     <= '0;
            state_reg <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (bus.rd_valid) begin
            dp_in1_reg <= bus.rd_data;
            // Diagonal pair: the same row serves as both operands
            if (j_reg == i_reg) begin
              dp_in2_reg <= bus.rd_data;
              wait_reg   <= '0;
              state_reg  <= COMPUTE;
            end else begin
              state_reg <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (bus.rd_valid) begin
            dp_in2_reg <= bus.rd_data;
            wait_reg   <= '0;
            state_reg  <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (wait_reg == LAT) begin
            res_data_reg  <= bus.dp_out;
            res_index_reg <= pair_index;
            res_valid_reg <= 1'b1;
            state_reg     <= EMIT;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        EMIT: begin
`ifdef GRAM_MIRROR_EN
          if (accept && i_reg != j_reg) begin
            res_index_reg <= mirror_index;
            state_reg     <= EMIT_M;
          end
`endif
        end
`ifdef GRAM_MIRROR_EN
        EMIT_M: begin
        end
`endif
        FIN: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (advance) begin
        res_valid_reg <= 1'b0;
        if (j_reg != LAST) begin
          j_reg     <= j_reg + 5'd1;
          state_reg <= LOAD_B;
        end else if (i_reg != LAST) begin
          i_reg     <= i_reg + 5'd1;
          j_reg     <= i_reg + 5'd1;
          state_reg <= LOAD_A;
        end else begin
          state_reg <= FIN;
        end
      end
    end
  end
endmodule

// File: tb/tb_gram_scheduler.sv
// Directed bench for gram_scheduler with N_VEC=3, SIZE=64: one instance with a
// combinational dot product, one with a 3-cycle pipelined dot product.
module tb_gram_scheduler;
  localparam int SZ = 64;
  localparam int NV = 3;
`ifdef GRAM_MIRROR_EN
  localparam int NRES = 9;
`else
  localparam int NRES = 6;
`endif

  typedef struct {
    int          pi;
    int          pj;
    logic [10:0] idx;
    logic [31:0] data_b;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gram_scheduler_if #(.SIZE(SZ)) g0 ();
  gram_scheduler_if #(.SIZE(SZ)) g3 ();

  gram_scheduler #(.SIZE(SZ), .N_VEC(NV), .DP_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(g0)
  );
  gram_scheduler #(.SIZE(SZ), .N_VEC(NV), .DP_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(g3)
  );

  logic [SZ*32-1:0] mem [NV];
  int   rd_delay;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t tab [NRES];

  logic [10:0] got_idx [$];
  logic [31:0] got_dat [$];
  logic [31:0] got_a   [$];
  int done_cnt, fetch0, fetch0_row0, wait0, wait_bad0;
  int lat3, lat_bad3, rises3;
  logic rv3_prev;
  int rcnt0, rcnt3;
  logic [31:0] pipe3 [3];

  function automatic logic [31:0] dot(input logic [SZ*32-1:0] a, input logic [SZ*32-1:0] b);
    longint acc = 0;
    for (int k = 0; k < SZ; k++) begin
      acc += (longint'($signed(a[32*k +: 32])) * longint'($signed(b[32*k +: 32]))) >>> 16;
    end
    return acc[31:0];
  endfunction

  assign g0.dp_out = dot(g0.dp_in1, g0.dp_in2);
  assign g3.dp_out = pipe3[2];

  always @(posedge clk) begin
    pipe3[0] <= dot(g3.dp_in1, g3.dp_in2);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  // Row buffer models: answer rd_req after rd_delay cycles with a 1-cycle rd_valid
  always @(posedge clk) begin
    #1;
    if (reset || g0.rd_valid) begin
      g0.rd_valid = 1'b0;
      rcnt0 = 0;
    end else if (g0.rd_req) begin
      if (rcnt0 >= rd_delay) begin
        g0.rd_valid = 1'b1;
        g0.rd_data  = mem[g0.rd_addr];
      end else rcnt0++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset || g3.rd_valid) begin
      g3.rd_valid = 1'b0;
      rcnt3 = 0;
    end else if (g3.rd_req) begin
      if (rcnt3 >= rd_delay) begin
        g3.rd_valid = 1'b1;
        g3.rd_data  = mem[g3.rd_addr];
      end else rcnt3++;
    end
  end

  // Monitors sample on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (g0.res_valid && g0.res_ready) begin
        got_idx.push_back(g0.res_index);
        got_dat.push_back(g0.res_data);
        got_a.push_back(g0.dp_in1[31:0]);
      end
      if (g3.res_valid && g3.res_ready) begin
        got_idx.push_back(g3.res_index);
        got_dat.push_back(g3.res_data);
        got_a.push_back(g3.dp_in1[31:0]);
      end
      if (g0.done || g3.done) done_cnt++;
      if (g0.rd_valid && g0.rd_req) begin
        fetch0++;
        if (g0.rd_addr == 5'd0) fetch0_row0++;
        if (wait0 != rd_delay) wait_bad0++;
        wait0 = 0;
      end else if (g0.rd_req) wait0++;
      if (g3.res_valid && !rv3_prev) begin
        rises3++;
        if (lat3 != 4) lat_bad3++;
      end
      rv3_prev = g3.res_valid;
      if (g3.rd_valid && g3.rd_req) lat3 = 0;
      else lat3++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_rows(input bit distinct);
    for (int r = 0; r < NV; r++)
      for (int k = 0; k < SZ; k++)
        mem[r][32*k +: 32] = distinct ? 32'((r + 1) << 16) : 32'h0001_0000;
  endtask

  task automatic clear_stats();
    got_idx.delete();
    got_dat.delete();
    got_a.delete();
    done_cnt = 0; fetch0 = 0; fetch0_row0 = 0; wait0 = 0; wait_bad0 = 0;
    lat3 = 0; lat_bad3 = 0; rises3 = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
  endtask

  // Compare collected results against the table (uniform or distinct rows)
  task automatic cmp_results(input string tag, input bit distinct, input bit chk_a);
    logic [10:0] ai;
    logic [31:0] ad, ea;
    check({tag, "_count"}, 64'(got_idx.size()), 64'(NRES));
    for (int k = 0; k < NRES; k++) begin
      ai = (k < got_idx.size()) ? got_idx[k] : 11'h7ff;
      ad = (k < got_dat.size()) ? got_dat[k] : 32'hdead_beef;
      check($sformatf("%s_idx%0d", tag, k), 64'(ai), 64'(tab[k].idx));
      check($sformatf("%s_dat%0d", tag, k), 64'(ad), distinct ? 64'(tab[k].data_b) : 64'h0040_0000);
      if (chk_a) begin
        ea = 32'((tab[k].pi + 1) << 16);
        check($sformatf("%s_rowA%0d", tag, k), 64'((k < got_a.size()) ? got_a[k] : 32'h0), 64'(ea));
      end
    end
  endtask

  task automatic wait_rv0(output bit ok);
    int n = 0;
    while (!g0.res_valid && n < 300) begin
      tick();
      n++;
    end
    ok = g0.res_valid;
  endtask

  initial begin
    bit          ok, stable, saw_rd, found;
    logic [10:0] hold_idx;
    logic [31:0] hold_dat;

`ifdef GRAM_MIRROR_EN
    tab[0] = '{0, 0, 11'd0, 32'h0040_0000};
    tab[1] = '{0, 1, 11'd1, 32'h0080_0000};
    tab[2] = '{0, 1, 11'd3, 32'h0080_0000};
    tab[3] = '{0, 2, 11'd2, 32'h00C0_0000};
    tab[4] = '{0, 2, 11'd6, 32'h00C0_0000};
    tab[5] = '{1, 1, 11'd4, 32'h0100_0000};
    tab[6] = '{1, 2, 11'd5, 32'h0180_0000};
    tab[7] = '{1, 2, 11'd7, 32'h0180_0000};
    tab[8] = '{2, 2, 11'd8, 32'h0240_0000};
`else
    tab[0] = '{0, 0, 11'd0, 32'h0040_0000};
    tab[1] = '{0, 1, 11'd1, 32'h0080_0000};
    tab[2] = '{0, 2, 11'd2, 32'h00C0_0000};
    tab[3] = '{1, 1, 11'd4, 32'h0100_0000};
    tab[4] = '{1, 2, 11'd5, 32'h0180_0000};
    tab[5] = '{2, 2, 11'd8, 32'h0240_0000};
`endif

    reset = 1'b1;
    rd_delay = 0;
    rv3_prev = 1'b0;
    g0.start = 1'b0; g0.res_ready = 1'b1; g0.rd_valid = 1'b0; g0.rd_data = '0;
    g3.start = 1'b0; g3.res_ready = 1'b1; g3.rd_valid = 1'b0; g3.rd_data = '0;
    set_rows(1'b0);
    clear_stats();
    repeat (3) tick();

    // Reset state
    check("rst_busy", 64'(g0.busy), 64'd0);
    check("rst_done", 64'(g0.done), 64'd0);
    check("rst_rd_req", 64'(g0.rd_req), 64'd0);
    check("rst_res_valid", 64'(g0.res_valid), 64'd0);
    check("rst_rd_addr", 64'(g0.rd_addr), 64'd0);
    check("rst_dp_index", 64'(g0.dp_index), 64'd0);
    check("rst_res_data", 64'(g0.res_data), 64'd0);
    check("rst_res_index", 64'(g0.res_index), 64'd0);
    check("rst_dp_in_zero", 64'(g0.dp_in1 == '0 && g0.dp_in2 == '0), 64'd1);
    reset = 1'b0;
    tick();

    // Pass with all-ones rows, consumer always ready
    clear_stats();
    g0.start = 1'b1; tick(); g0.start = 1'b0;
    check("a_busy_after_start", 64'(g0.busy), 64'd1);
    wait_done("a");
    cmp_results("a", 1'b0, 1'b0);
    check("a_done_width", 64'(done_cnt), 64'd1);
    check("a_busy_low", 64'(g0.busy), 64'd0);

    // Distinct rows, 5-cycle fetch latency
    set_rows(1'b1);
    rd_delay = 5;
    clear_stats();
    g0.start = 1'b1; tick(); g0.start = 1'b0;
    wait_done("b");
    cmp_results("b", 1'b1, 1'b1);
    check("b_fetches", 64'(fetch0), 64'd6);
    check("b_row0_once", 64'(fetch0_row0), 64'd1);
    check("b_wait_bad", 64'(wait_bad0), 64'd0);
    rd_delay = 0;

    // Backpressure: hold off the second result for 10 cycles
    clear_stats();
    g0.res_ready = 1'b0;
    g0.start = 1'b1; tick(); g0.start = 1'b0;
    wait_rv0(ok);
    check("bp_first_valid", 64'(ok), 64'd1);
    g0.res_ready = 1'b1; tick(); g0.res_ready = 1'b0;
    wait_rv0(ok);
    check("bp_second_valid", 64'(ok), 64'd1);
    hold_idx = g0.res_index;
    hold_dat = g0.res_data;
    stable = 1'b1;
    saw_rd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!g0.res_valid || g0.res_index != hold_idx || g0.res_data != hold_dat) stable = 1'b0;
      if (g0.rd_req) saw_rd = 1'b1;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_no_rd_req", 64'(saw_rd), 64'd0);
    check("bp_hold_idx", 64'(hold_idx), 64'(tab[1].idx));
    check("bp_hold_dat", 64'(hold_dat), 64'(tab[1].data_b));
    g0.res_ready = 1'b1;
    wait_done("bp");
    cmp_results("bp", 1'b1, 1'b0);

    // Reset while pair (1,2) is being emitted
    clear_stats();
    g0.res_ready = 1'b0;
    g0.start = 1'b1; tick(); g0.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (g0.res_valid) begin
        if (g0.res_index == 11'd5) found = 1'b1;
        else begin
          g0.res_ready = 1'b1; tick(); g0.res_ready = 1'b0;
        end
      end else tick();
    end
    check("rm_reached_pair12", 64'(found), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rm_res_valid", 64'(g0.res_valid), 64'd0);
    check("rm_busy", 64'(g0.busy), 64'd0);
    check("rm_no_done", 64'(done_cnt), 64'd0);
    tick();
    clear_stats();
    g0.res_ready = 1'b1;
    g0.start = 1'b1; tick(); g0.start = 1'b0;
    wait_done("rm");
    check("rm_first_idx", 64'((got_idx.size() > 0) ? got_idx[0] : 11'h7ff), 64'd0);
    check("rm_count", 64'(got_idx.size()), 64'(NRES));

    // Pipelined dot product; a second start mid-pass must be ignored
    clear_stats();
    g3.start = 1'b1; tick(); g3.start = 1'b0;
    repeat (5) tick();
    g3.start = 1'b1; tick(); g3.start = 1'b0;
    wait_done("l3");
    repeat (20) tick();
    cmp_results("l3", 1'b1, 1'b0);
    check("l3_rises", 64'(rises3), 64'd6);
    check("l3_latency_bad", 64'(lat_bad3), 64'd0);
    check("l3_done_once", 64'(done_cnt), 64'd1);
    check("l3_busy_low", 64'(g3.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
